// File: rtl/conv1d_scheduler_if.sv
// conv1d_scheduler_if: groups the row-control, engine-command and result-stream
// signals of the conv1d scheduler. The scheduler takes the master side; the
// environment (engine and result consumer) takes the slave side.
interface conv1d_scheduler_if #(
    parameter int INT32_SIZE = 32
);
    logic                  start;
    logic [INT32_SIZE-1:0] out_width;
    logic                  busy;
    logic                  done;
    logic [6:0]            eng_cmd;
    logic [INT32_SIZE-1:0] eng_inp1;
    logic [INT32_SIZE-1:0] eng_ret;
    logic                  res_valid;
    logic                  res_ready;
    logic [INT32_SIZE-1:0] res_data;
    logic [INT32_SIZE-1:0] res_index;

    modport master (
        input  start, out_width, eng_ret, res_ready,
        output busy, done, eng_cmd, eng_inp1, res_valid, res_data, res_index
    );

    modport slave (
        output start, out_width, eng_ret, res_ready,
        input  busy, done, eng_cmd, eng_inp1, res_valid, res_data, res_index
    );
endinterface

// File: rtl/conv1d_scheduler.sv
// conv1d_scheduler: sequences one conv1d row through the engine. For every
// output position it sets the input origin, triggers the compute, reads the
// result back and presents it on a valid/ready result stream.
// Optional feature: define CONV1D_SCHED_RELU_EN to clamp negative results to 0.
module conv1d_scheduler #(
    parameter int         INT32_SIZE = 32,
    parameter int         PADDING    = 4,
    parameter logic [6:0] NOP_CMD    = 7'd127
) (
    input logic clk,
    input logic reset_n,
    conv1d_scheduler_if.master bus
);

    localparam logic [6:0] CMD_SET_ORIGIN = 7'd42;
    localparam logic [6:0] CMD_COMPUTE    = 7'd41;
    localparam logic [6:0] CMD_READ       = 7'd43;

    localparam logic [INT32_SIZE-1:0] PAD_W = INT32_SIZE'(PADDING);
    localparam logic [INT32_SIZE-1:0] ONE   = INT32_SIZE'(1);

    typedef enum logic [2:0] {
        StIdle,
        StSetOrigin,
        StCompute,
        StRead,
        StCapture,
        StOutput
    } state_t;

    state_t                state_q, state_d;
    logic [INT32_SIZE-1:0] out_x_q, out_x_d;
    logic [INT32_SIZE-1:0] width_q, width_d;
    logic                  done_q, done_d;
    logic                  res_valid_q, res_valid_d;
    logic [INT32_SIZE-1:0] res_data_q, res_data_d;
    logic [INT32_SIZE-1:0] res_index_q, res_index_d;
    logic [6:0]            eng_cmd_d;
    logic [INT32_SIZE-1:0] eng_inp1_d;
    logic [INT32_SIZE-1:0] captured;

`ifdef CONV1D_SCHED_RELU_EN
    // Negative results (sign bit set) are clamped to zero.
    assign captured = bus.eng_ret[INT32_SIZE-1] ? '0 : bus.eng_ret;
`else
    assign captured = bus.eng_ret;
`endif

    // State and datapath registers; reset abandons any row in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            out_x_q     <= '0;
            width_q     <= '0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_index_q <= '0;
        end else begin
            state_q     <= state_d;
            out_x_q     <= out_x_d;
            width_q     <= width_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_index_q <= res_index_d;
        end
    end

    // Next-state logic and engine command decode.
    always_comb begin
        state_d     = state_q;
        out_x_d     = out_x_q;
        width_d     = width_q;
        done_d      = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_index_d = res_index_q;
        eng_cmd_d   = NOP_CMD;
        eng_inp1_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.out_width != '0) begin
                        width_d = bus.out_width;
                        out_x_d = '0;
                        state_d = StSetOrigin;
                    end else begin
                        // Empty row: acknowledge immediately without touching the engine.
                        done_d = 1'b1;
                    end
                end
            end
            StSetOrigin: begin
                eng_cmd_d  = CMD_SET_ORIGIN;
                eng_inp1_d = out_x_q - PAD_W;
                state_d    = StCompute;
            end
            StCompute: begin
                eng_cmd_d = CMD_COMPUTE;
                state_d   = StRead;
            end
            StRead: begin
                eng_cmd_d = CMD_READ;
                state_d   = StCapture;
            end
            StCapture: begin
                res_data_d  = captured;
                res_index_d = out_x_q;
                res_valid_d = 1'b1;
                state_d     = StOutput;
            end
            StOutput: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    if (out_x_q == width_q - ONE) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        out_x_d = out_x_q + ONE;
                        state_d = StSetOrigin;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.eng_cmd   = eng_cmd_d;
    assign bus.eng_inp1  = eng_inp1_d;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_index = res_index_q;

endmodule

// File: doc/conv1d_scheduler.md
CONV1D_SCHEDULER -- requirements
Module: conv1d_scheduler

Interface
REQ-001 SHALL have parameter INT32_SIZE, default 32, data and command operand width.
REQ-002 SHALL have parameter PADDING, default 4, left padding subtracted from each output index to form in_x_origin.
REQ-003 SHALL have parameter NOP_CMD, default 7'd127, idle command driven to the engine.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to run one conv1d row.
REQ-007 SHALL have port out_width  input  32  number of output positions; sampled when start is accepted.
REQ-008 SHALL have port busy  output  1  high from start acceptance until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last result is accepted.
REQ-010 SHALL have port eng_cmd  output  7  command to the conv1d engine.
REQ-011 SHALL have port eng_inp1  output  32  value operand to the engine.
REQ-012 SHALL have port eng_ret  input  32  engine result, valid the cycle after eng_cmd=43.
REQ-013 SHALL have ports res_valid/res_ready  output/input  1  result stream handshake.
REQ-014 SHALL have port res_data  output  32  result word.
REQ-015 SHALL have port res_index  output  32  output position of res_data.

Function
REQ-016 SHALL implement states IDLE, SET_ORIGIN, COMPUTE, READ, CAPTURE, OUTPUT.
REQ-017 SHALL drive eng_cmd=NOP_CMD in IDLE, CAPTURE and OUTPUT; SHALL never drive eng_cmd=0 (engine buffer clear).
REQ-018 IDLE: start=1 and out_width!=0 -> latch width, out_x=0, busy=1, go SET_ORIGIN; start with out_width=0 -> done pulse next cycle, stay IDLE.
REQ-019 SET_ORIGIN: eng_cmd=42, eng_inp1=signed(out_x - PADDING) (out_x=0 gives 0xFFFFFFFC); next COMPUTE.
REQ-020 COMPUTE: eng_cmd=41, eng_inp1=0; next READ.
REQ-021 READ: eng_cmd=43; next CAPTURE.
REQ-022 CAPTURE: register eng_ret into res_data, res_index=out_x, assert res_valid; next OUTPUT.
REQ-023 OUTPUT: hold res_valid, res_data, res_index stable until res_ready=1; on handshake deassert res_valid, then out_x+1 -> SET_ORIGIN, or if out_x==width-1 -> IDLE with done=1 and busy=0 in the same cycle.
REQ-024 Per-output latency with res_ready tied high: 5 cycles; N outputs take 5N cycles from start acceptance to done.
REQ-025 start while busy SHALL be ignored, with no change to the latched width.
REQ-026 out_x and width SHALL be 32-bit unsigned; origin subtraction SHALL be 32-bit two's complement.
REQ-027 res_ready while res_valid=0 SHALL have no effect.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, eng_cmd=NOP_CMD, eng_inp1=0, busy=0, done=0, res_valid=0, res_data=0, res_index=0, out_x=0.
REQ-029 Reset mid-run SHALL abandon the row with no done pulse; a new start SHALL be accepted on the first clock after release.

Configuration
REQ-030 With macro CONV1D_SCHED_RELU_EN defined, CAPTURE SHALL load max(signed eng_ret, 0) into res_data.
REQ-031 Without CONV1D_SCHED_RELU_EN, res_data SHALL equal eng_ret unmodified.

Verification
REQ-032 out_width=3, res_ready=1, engine model returning 10,20,30 -> eng_cmd sequence 42,41,43,NOP,NOP per output; origins 0xFFFFFFFC, 0xFFFFFFFD, 0xFFFFFFFE; results 10/0, 20/1, 30/2; done at cycle 15.
REQ-033 res_ready held low 4 cycles on index 1 -> res_valid, res_data and res_index stable; eng_cmd=NOP throughout the stall; done delayed 4 cycles.
REQ-034 start with out_width=0 -> done pulse next cycle; busy never high; no eng_cmd other than NOP.
REQ-035 start pulsed again mid-run with out_width=9 while running out_width=2 -> exactly 2 results, one done pulse.
REQ-036 reset_n low in COMPUTE of index 1 -> all outputs zero asynchronously; no done; restart with out_width=1 -> index 0 result.
REQ-037 eng_ret=0xFFFFFF9C (-100) -> res_data=0 with CONV1D_SCHED_RELU_EN, 0xFFFFFF9C without.
